id_ex_stage: RTL and testbench

Decode-to-execute pipeline register for the pipelined core. It sits directly downstream of the register file and captures RD1/RD2 together with the decoded instruction fields. Because the register file writes on the clock edge, it bypasses same-cycle write-back data into the captured operands. It also detects load-use hazards, stalls decode, and supports hold (stall) and bubble (flush) for execute.

---
 rtl/id_ex_if.sv | 48 ++++
 rtl/id_ex_stage.sv | 120 ++++++++++++
 tb/tb_id_ex_stage.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_if.sv
// Decode/execute bundle for the ID/EX pipeline register: decode-side inputs,
// write-back snoop, execute control, and the registered execute-side outputs.
interface id_ex_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 12
);
  logic              valid_d;
  logic [XLEN-1:0]   pc_d;
  logic [4:0]        rs1_d;
  logic [4:0]        rs2_d;
  logic [4:0]        rd_d;
  logic [XLEN-1:0]   imm_d;
  logic [CTRL_W-1:0] ctrl_d;
  logic [XLEN-1:0]   rd1_d;
  logic [XLEN-1:0]   rd2_d;

  logic              wb_we;
  logic [4:0]        wb_addr;
  logic [XLEN-1:0]   wb_data;

  logic              stall_e;
  logic              flush_e;

  logic              stall_d;
  logic              valid_e;
  logic [XLEN-1:0]   pc_e;
  logic [XLEN-1:0]   imm_e;
  logic [4:0]        rs1_e;
  logic [4:0]        rs2_e;
  logic [4:0]        rd_e;
  logic [CTRL_W-1:0] ctrl_e;
  logic [XLEN-1:0]   src_a_e;
  logic [XLEN-1:0]   src_b_e;

  modport master (
    output valid_d, pc_d, rs1_d, rs2_d, rd_d, imm_d, ctrl_d, rd1_d, rd2_d,
    output wb_we, wb_addr, wb_data, stall_e, flush_e,
    input  stall_d, valid_e, pc_e, imm_e, rs1_e, rs2_e, rd_e, ctrl_e,
    input  src_a_e, src_b_e
  );

  modport slave (
    input  valid_d, pc_d, rs1_d, rs2_d, rd_d, imm_d, ctrl_d, rd1_d, rd2_d,
    input  wb_we, wb_addr, wb_data, stall_e, flush_e,
    output stall_d, valid_e, pc_e, imm_e, rs1_e, rs2_e, rd_e, ctrl_e,
    output src_a_e, src_b_e
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass into captured operands,
// load-use hazard detection, and execute hold/flush.
module id_ex_stage #(
  parameter int XLEN      = 32,
  parameter int CTRL_W    = 12,
  parameter int MEMRD_BIT = 0
) (
  input  logic    clk,
  input  logic    rst_n,
  id_ex_if.slave  bus
);

  typedef enum logic [1:0] {EMPTY, FULL, HELD} state_t;

  state_t            state_q,   state_d;
  logic [XLEN-1:0]   ex_pc_q,   ex_pc_d;
  logic [XLEN-1:0]   ex_imm_q,  ex_imm_d;
  logic [4:0]        ex_rs1_q,  ex_rs1_d;
  logic [4:0]        ex_rs2_q,  ex_rs2_d;
  logic [4:0]        ex_rd_q,   ex_rd_d;
  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
  logic [XLEN-1:0]   ex_src_a_q, ex_src_a_d;
  logic [XLEN-1:0]   ex_src_b_q, ex_src_b_d;

  logic hazard;
  logic bubble;

  // The reg file writes on the same edge we capture on, so a matching
  // write-back must override the (stale) read data; x0 is never forwarded.
  function automatic logic [XLEN-1:0] fwd(
    input logic            we,
    input logic [4:0]      waddr,
    input logic [XLEN-1:0] wdata,
    input logic [4:0]      raddr,
    input logic [XLEN-1:0] rdata
  );
    if (we && (waddr != 5'd0) && (waddr == raddr)) return wdata;
    return rdata;
  endfunction

  assign hazard = bus.valid_d && (state_q != EMPTY) && ex_ctrl_q[MEMRD_BIT] &&
                  (ex_rd_q != 5'd0) &&
                  ((ex_rd_q == bus.rs1_d) || (ex_rd_q == bus.rs2_d));
  assign bus.stall_d = hazard && !bus.stall_e;

  // Flush beats everything; a load-use bubble only happens when execute can advance.
  assign bubble = bus.flush_e || (!bus.stall_e && bus.stall_d);

  always_comb begin
    state_d    = state_q;
    ex_pc_d    = ex_pc_q;
    ex_imm_d   = ex_imm_q;
    ex_rs1_d   = ex_rs1_q;
    ex_rs2_d   = ex_rs2_q;
    ex_rd_d    = ex_rd_q;
    ex_ctrl_d  = ex_ctrl_q;
    ex_src_a_d = ex_src_a_q;
    ex_src_b_d = ex_src_b_q;
    if (bubble) begin
      state_d    = EMPTY;
      ex_pc_d    = '0;
      ex_imm_d   = '0;
      ex_rs1_d   = '0;
      ex_rs2_d   = '0;
      ex_rd_d    = '0;
      ex_ctrl_d  = '0;
      ex_src_a_d = '0;
      ex_src_b_d = '0;
    end else if (bus.stall_e) begin
      state_d    = (state_q == EMPTY) ? EMPTY : HELD;
      ex_src_a_d = fwd(bus.wb_we, bus.wb_addr, bus.wb_data, ex_rs1_q, ex_src_a_q);
      ex_src_b_d = fwd(bus.wb_we, bus.wb_addr, bus.wb_data, ex_rs2_q, ex_src_b_q);
    end else begin
      state_d    = bus.valid_d ? FULL : EMPTY;
      ex_pc_d    = bus.pc_d;
      ex_imm_d   = bus.imm_d;
      ex_rs1_d   = bus.rs1_d;
      ex_rs2_d   = bus.rs2_d;
      ex_rd_d    = bus.rd_d;
      ex_ctrl_d  = bus.valid_d ? bus.ctrl_d : '0;
      ex_src_a_d = fwd(bus.wb_we, bus.wb_addr, bus.wb_data, bus.rs1_d, bus.rd1_d);
      ex_src_b_d = fwd(bus.wb_we, bus.wb_addr, bus.wb_data, bus.rs2_d, bus.rd2_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      ex_pc_q    <= '0;
      ex_imm_q   <= '0;
      ex_rs1_q   <= '0;
      ex_rs2_q   <= '0;
      ex_rd_q    <= '0;
      ex_ctrl_q  <= '0;
      ex_src_a_q <= '0;
      ex_src_b_q <= '0;
    end else begin
      state_q    <= state_d;
      ex_pc_q    <= ex_pc_d;
      ex_imm_q   <= ex_imm_d;
      ex_rs1_q   <= ex_rs1_d;
      ex_rs2_q   <= ex_rs2_d;
      ex_rd_q    <= ex_rd_d;
      ex_ctrl_q  <= ex_ctrl_d;
      ex_src_a_q <= ex_src_a_d;
      ex_src_b_q <= ex_src_b_d;
    end
  end

  assign bus.valid_e = (state_q != EMPTY);
  assign bus.pc_e    = ex_pc_q;
  assign bus.imm_e   = ex_imm_q;
  assign bus.rs1_e   = ex_rs1_q;
  assign bus.rs2_e   = ex_rs2_q;
  assign bus.rd_e    = ex_rd_q;
  assign bus.ctrl_e  = ex_ctrl_q;
  assign bus.src_a_e = ex_src_a_q;
  assign bus.src_b_e = ex_src_b_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected execute-slot contents are queued
// when stimulus is driven and compared one cycle later.
module tb_id_ex_stage;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [11:0] ctrl;
    logic [31:0] a;
    logic [31:0] b;
  } out_t;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  out_t exp_q[$];
  out_t e;
  out_t obs;

  id_ex_if #(.XLEN(32), .CTRL_W(12)) bus ();

  id_ex_stage #(.XLEN(32), .CTRL_W(12), .MEMRD_BIT(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign obs = {bus.valid_e, bus.pc_e, bus.imm_e, bus.rs1_e, bus.rs2_e, bus.rd_e,
                bus.ctrl_e, bus.src_a_e, bus.src_b_e};

  function automatic out_t mk(input logic v, input logic [31:0] pc,
                              input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                              input logic [31:0] imm, input logic [11:0] c,
                              input logic [31:0] a, input logic [31:0] b);
    out_t o;
    o = {v, pc, imm, r1, r2, rd, c, a, b};
    return o;
  endfunction

  task automatic set_dec(input logic v, input logic [31:0] pc,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                         input logic [31:0] imm, input logic [11:0] c,
                         input logic [31:0] d1, input logic [31:0] d2);
    bus.valid_d = v;  bus.pc_d = pc;  bus.rs1_d = r1; bus.rs2_d = r2; bus.rd_d = rd;
    bus.imm_d = imm;  bus.ctrl_d = c; bus.rd1_d = d1; bus.rd2_d = d2;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] addr, input logic [31:0] data);
    bus.wb_we = we; bus.wb_addr = addr; bus.wb_data = data;
  endtask

  task automatic set_ctl(input logic st, input logic fl);
    bus.stall_e = st; bus.flush_e = fl;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0, 0);
    set_ctl(0, 0);
    #2;
    vectors++;
    if (obs !== '0 || bus.stall_d !== 1'b0) begin
      miscompares++; $display("FAIL reset_idle: got %h want 0", obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_dec(1, 32'h100, 5'd1, 5'd2, 5'd3, 32'h8, 12'h0F0, 32'h1111, 32'h2222);
    exp_q.push_back(mk(1, 32'h100, 5'd1, 5'd2, 5'd3, 32'h8, 12'h0F0, 32'h1111, 32'h2222));
    @(posedge clk); #1; e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL pre_reset_load: got %h want %h", obs, e); end
    #2 rst_n = 1'b0;
    #1; vectors++;
    if (obs !== '0) begin miscompares++; $display("FAIL async_reset: got %h want 0", obs); end
    #1 rst_n = 1'b1;
    set_dec(1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(mk(1, 32'h40, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1; e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL reset_first_capture: got %h want %h", obs, e); end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    set_dec(1, 32'h200, 5'd5, 5'd6, 5'd9, 32'h4, 12'h002, 32'h11, 32'h22);
    set_wb(1, 5'd5, 32'hAB);
    exp_q.push_back(mk(1, 32'h200, 5'd5, 5'd6, 5'd9, 32'h4, 12'h002, 32'hAB, 32'h22));
    @(posedge clk); #1; e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL bypass_rs1: got %h want %h", obs, e); end
    @(negedge clk);
    set_dec(1, 32'h204, 5'd0, 5'd6, 5'd1, 32'h0, 12'h004, 32'h33, 32'h44);
    set_wb(1, 5'd0, 32'hAB);
    exp_q.push_back(mk(1, 32'h204, 5'd0, 5'd6, 5'd1, 32'h0, 12'h004, 32'h33, 32'h44));
    @(posedge clk); #1; e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL bypass_x0: got %h want %h", obs, e); end
    @(negedge clk);
    set_dec(1, 32'h208, 5'd2, 5'd6, 5'd1, 32'h0, 12'h006, 32'h55, 32'h44);
    set_wb(1, 5'd6, 32'hCD);
    exp_q.push_back(mk(1, 32'h208, 5'd2, 5'd6, 5'd1, 32'h0, 12'h006, 32'h55, 32'hCD));
    @(posedge clk); #1; e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL bypass_rs2: got %h want %h", obs, e); end
    @(negedge clk);
    set_dec(1, 32'h20C, 5'd5, 5'd5, 5'd1, 32'h0, 12'h008, 32'h66, 32'h77);
    set_wb(0, 5'd5, 32'hEE);
    exp_q.push_back(mk(1, 32'h20C, 5'd5, 5'd5, 5'd1, 32'h0, 12'h008, 32'h66, 32'h77));
    @(posedge clk); #1; e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL bypass_we_low: got %h want %h", obs, e); end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    set_wb(0, 0, 0);
    set_dec(1, 32'h300, 5'd1, 5'd2, 5'd7, 32'h10, 12'h001, 32'h1000, 32'h0);
    exp_q.push_back(mk(1, 32'h300, 5'd1, 5'd2, 5'd7, 32'h10, 12'h001, 32'h1000, 32'h0));
    @(posedge clk); #1; e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL lu_load: got %h want %h", obs, e); end
    @(negedge clk);
    set_dec(1, 32'h304, 5'd8, 5'd7, 5'd10, 32'h0, 12'h0A0, 32'h77, 32'hDEAD);
    #1; vectors++;
    if (bus.stall_d !== 1'b1) begin miscompares++; $display("FAIL lu_stall_d: got %b want 1", bus.stall_d); end
    exp_q.push_back('0);
    @(posedge clk); #1; e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL lu_bubble: got %h want %h", obs, e); end
    @(negedge clk);
    set_wb(1, 5'd7, 32'hBEEF);
    #1; vectors++;
    if (bus.stall_d !== 1'b0) begin miscompares++; $display("FAIL lu_release: got %b want 0", bus.stall_d); end
    exp_q.push_back(mk(1, 32'h304, 5'd8, 5'd7, 5'd10, 32'h0, 12'h0A0, 32'h77, 32'hBEEF));
    @(posedge clk); #1; e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL lu_reissue: got %h want %h", obs, e); end
  endtask

  task automatic test_hold_refresh();
    @(negedge clk);
    set_wb(0, 0, 0);
    set_dec(1, 32'h400, 5'd3, 5'd4, 5'd5, 32'h20, 12'h0C0, 32'h10, 32'h20);
    exp_q.push_back(mk(1, 32'h400, 5'd3, 5'd4, 5'd5, 32'h20, 12'h0C0, 32'h10, 32'h20));
    @(posedge clk); #1; e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL hold_load: got %h want %h", obs, e); end
    @(negedge clk);
    set_dec(1, 32'h500, 5'd3, 5'd4, 5'd6, 32'h24, 12'h0C2, 32'h99, 32'h98);
    set_ctl(1, 0);
    exp_q.push_back(mk(1, 32'h400, 5'd3, 5'd4, 5'd5, 32'h20, 12'h0C0, 32'h10, 32'h20));
    @(posedge clk); #1; e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL hold_c1: got %h want %h", obs, e); end
    @(negedge clk);
    set_wb(1, 5'd3, 32'h55);
    exp_q.push_back(mk(1, 32'h400, 5'd3, 5'd4, 5'd5, 32'h20, 12'h0C0, 32'h55, 32'h20));
    @(posedge clk); #1; e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL hold_c2_refresh: got %h want %h", obs, e); end
    @(negedge clk);
    set_wb(1, 5'd9, 32'h66);
    exp_q.push_back(mk(1, 32'h400, 5'd3, 5'd4, 5'd5, 32'h20, 12'h0C0, 32'h55, 32'h20));
    @(posedge clk); #1; e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL hold_c3: got %h want %h", obs, e); end
    @(negedge clk);
    set_ctl(0, 0);
    set_wb(0, 0, 0);
    exp_q.push_back(mk(1, 32'h500, 5'd3, 5'd4, 5'd6, 32'h24, 12'h0C2, 32'h99, 32'h98));
    @(posedge clk); #1; e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL hold_release: got %h want %h", obs, e); end
  endtask

  task automatic test_flush_priority();
    @(negedge clk);
    set_ctl(1, 1);
    set_dec(1, 32'h600, 5'd1, 5'd2, 5'd3, 32'h4, 12'h0FE, 32'h5, 32'h6);
    exp_q.push_back('0);
    @(posedge clk); #1; e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL flush_over_stall: got %h want %h", obs, e); end
    @(negedge clk);
    set_ctl(0, 1);
    exp_q.push_back('0);
    @(posedge clk); #1; e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL flush_only: got %h want %h", obs, e); end
    @(negedge clk);
    set_ctl(0, 0);
    exp_q.push_back(mk(1, 32'h600, 5'd1, 5'd2, 5'd3, 32'h4, 12'h0FE, 32'h5, 32'h6));
    @(posedge clk); #1; e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL flush_recover: got %h want %h", obs, e); end
  endtask

  task automatic test_hazard_corners();
    @(negedge clk);
    set_dec(1, 32'h700, 5'd1, 5'd2, 5'd0, 32'h0, 12'h001, 32'h1, 32'h2);
    exp_q.push_back(mk(1, 32'h700, 5'd1, 5'd2, 5'd0, 32'h0, 12'h001, 32'h1, 32'h2));
    @(posedge clk); #1; e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL x0_load: got %h want %h", obs, e); end
    @(negedge clk);
    set_dec(1, 32'h704, 5'd0, 5'd0, 5'd4, 32'h0, 12'h010, 32'h3, 32'h4);
    #1; vectors++;
    if (bus.stall_d !== 1'b0) begin miscompares++; $display("FAIL x0_no_hazard: got %b want 0", bus.stall_d); end
    exp_q.push_back(mk(1, 32'h704, 5'd0, 5'd0, 5'd4, 32'h0, 12'h010, 32'h3, 32'h4));
    @(posedge clk); #1; e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL x0_pass: got %h want %h", obs, e); end
    @(negedge clk);
    set_dec(1, 32'h708, 5'd1, 5'd2, 5'd7, 32'h0, 12'h001, 32'h5, 32'h6);
    exp_q.push_back(mk(1, 32'h708, 5'd1, 5'd2, 5'd7, 32'h0, 12'h001, 32'h5, 32'h6));
    @(posedge clk); #1; e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL hz_load7: got %h want %h", obs, e); end
    @(negedge clk);
    set_dec(1, 32'h70C, 5'd7, 5'd0, 5'd8, 32'h0, 12'h020, 32'h9, 32'hA);
    set_ctl(1, 0);
    #1; vectors++;
    if (bus.stall_d !== 1'b0) begin miscompares++; $display("FAIL hz_masked: got %b want 0", bus.stall_d); end
    exp_q.push_back(mk(1, 32'h708, 5'd1, 5'd2, 5'd7, 32'h0, 12'h001, 32'h5, 32'h6));
    @(posedge clk); #1; e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL hz_hold: got %h want %h", obs, e); end
    @(negedge clk);
    set_ctl(0, 0);
    #1; vectors++;
    if (bus.stall_d !== 1'b1) begin miscompares++; $display("FAIL hz_after_hold: got %b want 1", bus.stall_d); end
    exp_q.push_back('0);
    @(posedge clk); #1; e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL hz_bubble: got %h want %h", obs, e); end
    @(negedge clk);
    exp_q.push_back(mk(1, 32'h70C, 5'd7, 5'd0, 5'd8, 32'h0, 12'h020, 32'h9, 32'hA));
    @(posedge clk); #1; e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL hz_reissue: got %h want %h", obs, e); end
    @(negedge clk);
    set_dec(0, 32'h800, 5'd1, 5'd2, 5'd3, 32'h5, 12'hFFF, 32'h11, 32'h22);
    exp_q.push_back(mk(0, 32'h800, 5'd1, 5'd2, 5'd3, 32'h5, 12'h000, 32'h11, 32'h22));
    @(posedge clk); #1; e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL invalid_decode: got %h want %h", obs, e); end
  endtask

  task automatic test_back_to_back();
    out_t cur, n;
    logic v, st, fl, we, sd_exp;
    logic [4:0] r1, r2, rd, wa;
    logic [31:0] pc, imm, d1, d2, wd;
    logic [11:0] c;
    @(negedge clk);
    set_ctl(0, 1);
    set_wb(0, 0, 0);
    exp_q.push_back('0);
    @(posedge clk); #1; e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL b2b_start: got %h want %h", obs, e); end
    cur = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      v  = ($urandom_range(0, 3) != 0);
      pc = $urandom; imm = $urandom; d1 = $urandom; d2 = $urandom; wd = $urandom;
      r1 = 5'($urandom_range(0, 7)); r2 = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7)); wa = 5'($urandom_range(0, 7));
      c  = 12'($urandom); we = 1'($urandom);
      st = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 9) == 0);
      set_dec(v, pc, r1, r2, rd, imm, c, d1, d2);
      set_wb(we, wa, wd);
      set_ctl(st, fl);
      sd_exp = v && cur.v && cur.ctrl[0] && (cur.rd != 5'd0) &&
               ((cur.rd == r1) || (cur.rd == r2)) && !st;
      #1; vectors++;
      if (bus.stall_d !== sd_exp) begin
        miscompares++; $display("FAIL b2b_stall_d[%0d]: got %b want %b", i, bus.stall_d, sd_exp);
      end
      if (fl || sd_exp) n = '0;
      else if (st) begin
        n = cur;
        if (we && wa != 5'd0 && wa == cur.rs1) n.a = wd;
        if (we && wa != 5'd0 && wa == cur.rs2) n.b = wd;
      end else begin
        n = mk(v, pc, r1, r2, rd, imm, v ? c : 12'h000,
               (we && wa != 5'd0 && wa == r1) ? wd : d1,
               (we && wa != 5'd0 && wa == r2) ? wd : d2);
      end
      exp_q.push_back(n);
      @(posedge clk); #1; e = exp_q.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL b2b_out[%0d]: got %h want %h", i, obs, e); end
      cur = n;
    end
  endtask

  task automatic test_reset_in_hold();
    @(negedge clk);
    set_ctl(0, 0);
    set_wb(0, 0, 0);
    set_dec(1, 32'h900, 5'd1, 5'd2, 5'd3, 32'h1, 12'h040, 32'hA1, 32'hA2);
    exp_q.push_back(mk(1, 32'h900, 5'd1, 5'd2, 5'd3, 32'h1, 12'h040, 32'hA1, 32'hA2));
    @(posedge clk); #1; e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL rh_load: got %h want %h", obs, e); end
    @(negedge clk);
    set_ctl(1, 0);
    exp_q.push_back(mk(1, 32'h900, 5'd1, 5'd2, 5'd3, 32'h1, 12'h040, 32'hA1, 32'hA2));
    @(posedge clk); #1; e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL rh_held: got %h want %h", obs, e); end
    #2 rst_n = 1'b0;
    #1; vectors++;
    if (obs !== '0) begin miscompares++; $display("FAIL rh_async_reset: got %h want 0", obs); end
    #1 rst_n = 1'b1;
    set_ctl(1, 0);
    exp_q.push_back('0);
    @(posedge clk); #1; e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL rh_stays_empty: got %h want %h", obs, e); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_load_use();
    test_hold_refresh();
    test_flush_priority();
    test_hazard_corners();
    test_back_to_back();
    test_reset_in_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
